// File: rtl/sd_sector_sched.sv
// Sector-run sequencer in front of the SD read port: one load request becomes a
// paced series of rd_start_en pulses with start watchdog/retry. Option: SD_SCHED_WORDCHK_EN.
module sd_sector_sched #(
    parameter int SEC_CNT_W = 16,
    parameter int GAP_CYC   = 8,
    parameter int TMO_CYC   = 1024,
    parameter int RETRY_MAX = 3
) (
    input  logic                 clk_ref,
    input  logic                 rst,
    input  logic                 sd_init_done,
    input  logic                 load_req,
    input  logic [31:0]          base_addr,
    input  logic [SEC_CNT_W-1:0] sec_cnt,
    input  logic                 rd_busy,
`ifdef SD_SCHED_WORDCHK_EN
    input  logic                 rd_val_en,
`endif
    output logic                 rd_start_en,
    output logic [31:0]          rd_sec_addr,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 load_err,
    output logic [SEC_CNT_W-1:0] sec_idx
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t               state, state_nxt;
    logic [SEC_CNT_W-1:0] cnt_q;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [RTY_W-1:0]     retry_cnt;

    logic accept, sec_fin, retry, set_err;
    logic active, can_retry, words_ok;

    assign active    = state inside {S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP};
    assign can_retry = retry_cnt < RTY_W'(RETRY_MAX);

`ifdef SD_SCHED_WORDCHK_EN
    // A full 512-byte sector arrives as exactly 256 word strobes.
    logic [8:0] wcnt;
    logic [9:0] wsum;
    assign wsum     = {1'b0, wcnt} + {9'd0, rd_val_en};
    assign words_ok = (wsum == 10'd256);

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
        end else if (state == S_ISSUE) begin
            wcnt <= '0;
        end else if ((state == S_WAIT_HI || state == S_WAIT_LO) && rd_val_en && wcnt != 9'h1FF) begin
            wcnt <= wcnt + 9'd1;
        end
    end
`else
    assign words_ok = 1'b1;
`endif

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sec_fin   = 1'b0;
        retry     = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_req) begin
                    if (sec_cnt != '0) begin
                        accept    = 1'b1;
                        state_nxt = S_WAIT_INIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT_INIT: if (sd_init_done) state_nxt = S_ISSUE;
            // Hold off the pulse while a stale read is still in flight.
            S_ISSUE: if (!rd_busy) state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (rd_busy) begin
                    state_nxt = S_WAIT_LO;
                end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                    if (can_retry) begin
                        retry     = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = S_ERR;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!rd_busy) begin
                    if (!words_ok) begin
                        if (can_retry) begin
                            retry     = 1'b1;
                            state_nxt = S_ISSUE;
                        end else begin
                            set_err   = 1'b1;
                            state_nxt = S_ERR;
                        end
                    end else begin
                        sec_fin   = 1'b1;
                        state_nxt = (sec_idx + SEC_CNT_W'(1) == cnt_q) ? S_DONE : S_GAP;
                    end
                end
            end
            S_GAP:  if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nxt = S_ISSUE;
            S_DONE: state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Card loss overrides whatever the read sequence was about to do.
        if (active && !sd_init_done) begin
            state_nxt = S_ERR;
            set_err   = 1'b1;
            retry     = 1'b0;
            sec_fin   = 1'b0;
        end
    end

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            rd_sec_addr <= '0;
            sec_idx     <= '0;
            load_err    <= 1'b0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            if (accept) begin
                cnt_q       <= sec_cnt;
                rd_sec_addr <= base_addr;
                sec_idx     <= '0;
                load_err    <= 1'b0;
                retry_cnt   <= '0;
            end
            if (set_err) load_err  <= 1'b1;
            if (retry)   retry_cnt <= retry_cnt + RTY_W'(1);
            if (sec_fin) begin
                sec_idx     <= sec_idx + SEC_CNT_W'(1);
                rd_sec_addr <= rd_sec_addr + 32'd1;
                retry_cnt   <= '0;
            end
            if (state == S_ISSUE)        tmo_cnt <= '0;
            else if (state == S_WAIT_HI) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else                gap_cnt <= '0;
        end
    end

    assign rd_start_en = (state == S_ISSUE) && sd_init_done && !rd_busy;
    assign load_busy   = active || (state == S_WAIT_INIT);
    assign load_done   = (state == S_DONE);

endmodule

// File: tb/tb_sd_sector_sched.sv
// Scoreboarded bench for sd_sector_sched with a behavioural SD read-port model.
`timescale 1ns/1ps
module tb_sd_sector_sched;
    localparam int SEC_CNT_W = 16;
    localparam int GAP_CYC   = 8;
    localparam int TMO_CYC   = 1024;
    localparam int RETRY_MAX = 3;

    logic                 clk_ref = 1'b0;
    logic                 rst = 1'b0;
    logic                 sd_init_done = 1'b0;
    logic                 load_req = 1'b0;
    logic [31:0]          base_addr = '0;
    logic [SEC_CNT_W-1:0] sec_cnt = '0;
    logic                 rd_busy = 1'b0;
    logic                 rd_val_en = 1'b0;
    logic                 rd_start_en, load_busy, load_done, load_err;
    logic [31:0]          rd_sec_addr;
    logic [SEC_CNT_W-1:0] sec_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    sd_sector_sched #(
        .SEC_CNT_W(SEC_CNT_W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC), .RETRY_MAX(RETRY_MAX)
    ) dut (
        .clk_ref(clk_ref), .rst(rst), .sd_init_done(sd_init_done), .load_req(load_req),
        .base_addr(base_addr), .sec_cnt(sec_cnt), .rd_busy(rd_busy),
`ifdef SD_SCHED_WORDCHK_EN
        .rd_val_en(rd_val_en),
`endif
        .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .sec_idx(sec_idx)
    );

    logic [31:0] exp_q[$];
    logic [31:0] obs_addr[$];
    int obs_cyc[$];
    int fall_cyc[$];
    int words_q[$];
    int done_cnt, bad_start, drop_cyc, stop_cyc, req_cyc;
    int busy_len = 300;
    int poke_t = -1;
    int drop_start = -1;
    int drop_ph = 0;
    bit model_resp = 1'b1;
    bit timed_out;

    task automatic clear_sb();
        exp_q.delete(); obs_addr.delete(); obs_cyc.delete(); fall_cyc.delete(); words_q.delete();
    endtask

    task automatic start_load(input logic [31:0] b, input logic [SEC_CNT_W-1:0] n);
        @(negedge clk_ref);
        base_addr = b; sec_cnt = n; load_req = 1'b1; req_cyc = cyc;
    endtask

    // Cycle engine: samples on negedge, plays the SD controller, stops when the load ends.
    task automatic run_load(input int budget);
        int ph, nstart, nwords;
        bit seen_busy;
        ph = -1; nstart = 0; nwords = 256; seen_busy = 1'b0;
        timed_out = 1'b1; done_cnt = 0; bad_start = 0; drop_cyc = -1; stop_cyc = -1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk_ref);
            load_req = 1'b0;
            if (rd_start_en) begin
                obs_addr.push_back(rd_sec_addr);
                obs_cyc.push_back(cyc);
                if (rd_busy || !sd_init_done) bad_start++;
                nstart++; ph = 0;
                nwords = (words_q.size() > 0) ? words_q.pop_front() : 256;
            end else if (ph >= 0) begin
                ph++;
            end
            if (load_done) done_cnt++;
            if (load_busy) seen_busy = 1'b1;
            if (load_done || (seen_busy && !load_busy)) begin
                timed_out = 1'b0; stop_cyc = cyc;
                break;
            end
            if (t == poke_t) begin
                load_req = 1'b1; base_addr = 32'hDEAD_0000; sec_cnt = 7;
            end
            if (ph == 5 + busy_len) begin
                fall_cyc.push_back(cyc); ph = -1;
            end
            rd_busy   = model_resp && ph >= 5;
            rd_val_en = rd_busy && (ph - 5) < nwords;
            if (nstart == drop_start && ph == drop_ph && drop_cyc < 0) begin
                sd_init_done = 1'b0; drop_cyc = cyc;
            end
        end
        rd_busy = 1'b0; rd_val_en = 1'b0; load_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_ref);
        checks++;
        if ({rd_start_en, load_busy, load_done, load_err, rd_sec_addr, sec_idx} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got start=%b busy=%b done=%b err=%b addr=%h idx=%0d want all 0",
                     rd_start_en, load_busy, load_done, load_err, rd_sec_addr, sec_idx);
        end
        rst = 1'b1;
        @(negedge clk_ref);
    endtask

    task automatic test_basic();
        logic [31:0] e;
        clear_sb();
        sd_init_done = 1'b1; model_resp = 1'b1; busy_len = 600; poke_t = 300;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0000_4100 + i);
        start_load(32'h0000_4100, 3);
        run_load(5000);
        poke_t = -1;
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout load did not finish"); end
        checks++; if (obs_addr.size() != 3) begin failures++; $display("FAIL basic_start_count got %0d want 3", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++;
            if (obs_addr[i] !== e) begin failures++; $display("FAIL basic_addr[%0d] got %h want %h", i, obs_addr[i], e); end
            if (i > 0 && fall_cyc.size() >= i) begin
                checks++;
                if (obs_cyc[i] - fall_cyc[i-1] < GAP_CYC) begin
                    failures++; $display("FAIL basic_gap[%0d] got %0d want >=%0d", i, obs_cyc[i] - fall_cyc[i-1], GAP_CYC);
                end
            end
        end
        if (obs_cyc.size() > 0) begin
            checks++;
            if (obs_cyc[0] - req_cyc != 2) begin failures++; $display("FAIL basic_latency got %0d want 2", obs_cyc[0] - req_cyc); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done got %0d want 1", done_cnt); end
        checks++; if (sec_idx !== 16'd3) begin failures++; $display("FAIL basic_sec_idx got %0d want 3", sec_idx); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL basic_err got %b want 0", load_err); end
        checks++; if (bad_start != 0) begin failures++; $display("FAIL basic_illegal_start got %0d want 0", bad_start); end
    endtask

    task automatic test_init_wait();
        int early, rise_cyc;
        clear_sb();
        sd_init_done = 1'b0; busy_len = 300; early = 0;
        exp_q.push_back(32'h0000_0200);
        start_load(32'h0000_0200, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_ref);
            load_req = 1'b0;
            if (rd_start_en) early++;
        end
        checks++; if (early != 0) begin failures++; $display("FAIL init_early_start got %0d want 0", early); end
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL init_busy_wait got %b want 1", load_busy); end
        sd_init_done = 1'b1; rise_cyc = cyc;
        run_load(2000);
        checks++;
        if (obs_cyc.size() != 1 || obs_cyc[0] - rise_cyc < 1 || obs_cyc[0] - rise_cyc > 2) begin
            failures++; $display("FAIL init_start_after_rise starts=%0d delta=%0d want 1 start at 1..2",
                                 obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] - rise_cyc : -1);
        end else begin
            checks++;
            if (obs_addr[0] !== exp_q.pop_front()) begin failures++; $display("FAIL init_addr got %h want 00000200", obs_addr[0]); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL init_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_timeout();
        logic [31:0] e;
        clear_sb();
        model_resp = 1'b0;
        for (int i = 0; i < 1 + RETRY_MAX; i++) exp_q.push_back(32'h0000_7000);
        start_load(32'h0000_7000, 2);
        run_load(6000);
        model_resp = 1'b1;
        checks++; if (timed_out) begin failures++; $display("FAIL tmo_finish load did not end"); end
        checks++; if (obs_addr.size() != 1 + RETRY_MAX) begin failures++; $display("FAIL tmo_start_count got %0d want %0d", obs_addr.size(), 1 + RETRY_MAX); end
        for (int i = 0; i < obs_addr.size(); i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++;
            if (obs_addr[i] !== e) begin failures++; $display("FAIL tmo_addr[%0d] got %h want %h", i, obs_addr[i], e); end
            if (i > 0) begin
                checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != TMO_CYC + 1) begin
                    failures++; $display("FAIL tmo_spacing[%0d] got %0d want %0d", i, obs_cyc[i] - obs_cyc[i-1], TMO_CYC + 1);
                end
            end
        end
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL tmo_err got %b want 1", load_err); end
        checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got %b want 0", load_busy); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL tmo_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_init_drop();
        clear_sb();
        busy_len = 600; drop_start = 2; drop_ph = 100;
        exp_q.push_back(32'h0000_9000); exp_q.push_back(32'h0000_9001);
        start_load(32'h0000_9000, 3);
        run_load(5000);
        drop_start = -1;
        checks++;
        if (timed_out || drop_cyc < 0 || stop_cyc - drop_cyc != 1) begin
            failures++; $display("FAIL drop_err_latency got %0d want 1", stop_cyc - drop_cyc);
        end
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL drop_err got %b want 1", load_err); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL drop_done got %0d want 0", done_cnt); end
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== exp_q[0] || obs_addr[1] !== exp_q[1]) begin
            failures++; $display("FAIL drop_addrs got %0d starts first=%h want 2 starts 00009000,00009001",
                                 obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 32'h0);
        end
        clear_sb();
        sd_init_done = 1'b1; busy_len = 300;
        exp_q.push_back(32'h0000_A000);
        repeat (2) @(negedge clk_ref);
        start_load(32'h0000_A000, 1);
        @(negedge clk_ref);
        load_req = 1'b0;
        checks++;
        if (load_err !== 1'b0 || load_busy !== 1'b1) begin
            failures++; $display("FAIL drop_reload_clear got err=%b busy=%b want err=0 busy=1", load_err, load_busy);
        end
        run_load(2000);
        checks++;
        if (done_cnt != 1 || obs_addr.size() != 1 || obs_addr[0] !== exp_q[0]) begin
            failures++; $display("FAIL drop_reload_run got done=%0d starts=%0d want done=1 one start at 0000a000", done_cnt, obs_addr.size());
        end
    endtask

    task automatic test_wrap_zero();
        clear_sb();
        busy_len = 300;
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0000_0000);
        start_load(32'hFFFF_FFFF, 2);
        run_load(3000);
        checks++; if (obs_addr.size() != 2) begin failures++; $display("FAIL wrap_count got %0d want 2", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            checks++;
            if (obs_addr[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_addr[%0d] got %h want %h", i, obs_addr[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1 || sec_idx !== 16'd2) begin failures++; $display("FAIL wrap_done got done=%0d idx=%0d want 1,2", done_cnt, sec_idx); end
        clear_sb();
        start_load(32'h0000_1234, 0);
        run_load(20);
        checks++;
        if (timed_out || done_cnt != 1 || load_busy !== 1'b0 || obs_addr.size() != 0) begin
            failures++; $display("FAIL zero_cnt got done=%0d busy=%b starts=%0d want done=1 busy=0 starts=0",
                                 done_cnt, load_busy, obs_addr.size());
        end
        checks++;
        if (stop_cyc - req_cyc != 1) begin failures++; $display("FAIL zero_latency got %0d want 1", stop_cyc - req_cyc); end
    endtask

`ifdef SD_SCHED_WORDCHK_EN
    task automatic test_wordchk();
        clear_sb();
        busy_len = 600;
        words_q.push_back(255); words_q.push_back(256);
        exp_q.push_back(32'h0000_5000); exp_q.push_back(32'h0000_5000);
        start_load(32'h0000_5000, 1);
        run_load(4000);
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== exp_q[0] || obs_addr[1] !== exp_q[1]) begin
            failures++; $display("FAIL wchk_starts got %0d want 2 at 00005000", obs_addr.size());
        end
        checks++;
        if (done_cnt != 1 || load_err !== 1'b0) begin
            failures++; $display("FAIL wchk_result got done=%0d err=%b want 1,0", done_cnt, load_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_init_wait();
        test_timeout();
        test_init_drop();
        test_wrap_zero();
`ifdef SD_SCHED_WORDCHK_EN
        test_wordchk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
